// File: rtl/sprite_arb_pkg.sv
// Shared widths, in-flight pipe types and helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

   localparam int SPR_N_REQ  = 4;
   localparam int SPR_ADDR_W = 10;
   localparam int SPR_DATA_W = 8;
   localparam int ROM_LAT    = 1;
   localparam int REQ_ID_W   = (SPR_N_REQ > 1) ? $clog2(SPR_N_REQ) : 1;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } pipe_stage_t;

   function automatic logic [SPR_N_REQ-1:0] onehot_id(input req_id_t id);
      logic [SPR_N_REQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin pick: scan req_valid starting at ptr, wrapping modulo N_REQ; first set bit wins.
module rr_pick
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ = SPR_N_REQ
) (
   input  logic [N_REQ-1:0] req_valid,
   input  req_id_t          ptr,
   output req_id_t          winner,
   output logic             grant
);

   int      idx;
   req_id_t cand;

   // NOTE: every output gets a default before the loop, so no latch can be inferred.
   always_comb begin
      winner = '0;
      grant  = 1'b0;
      idx    = 0;
      cand   = '0;
      // Walk offsets from farthest to nearest so the nearest valid index is written last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = req_id_t'(idx);
         if (req_valid[cand]) begin
            winner = cand;
            grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among the pixel-pipeline layers.
module sprite_rom_arbiter #(
   parameter int N_REQ   = sprite_arb_pkg::SPR_N_REQ,
   parameter int ADDR_W  = sprite_arb_pkg::SPR_ADDR_W,
   parameter int DATA_W  = sprite_arb_pkg::SPR_DATA_W,
   parameter int ROM_LAT = sprite_arb_pkg::ROM_LAT
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [DATA_W-1:0]       rom_q,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    busy
);

   import sprite_arb_pkg::*;

   req_id_t           ptr;
   req_id_t           winner;
   logic              grant;
   logic [ADDR_W-1:0] last_addr;
   pipe_stage_t       pipe [ROM_LAT];

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .winner    (winner),
      .grant     (grant)
   );

   always_comb begin
      req_ready = '0;
      if (grant && reset_n) req_ready = onehot_id(winner);
   end

   // Idle cycles replay the last granted address so the ROM input stays quiet.
   always_comb begin
      rom_address = last_addr;
      if (grant) rom_address = req_addr[int'(winner)*ADDR_W +: ADDR_W];
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < ROM_LAT; k++) busy = busy | pipe[k].vld;
   end

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr       <= '0;
         last_addr <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         // NOTE: the pipe array is reset; stale vld bits would otherwise emit phantom responses.
         for (int k = 0; k < ROM_LAT; k++) pipe[k] <= '0;
      end else begin
         if (grant) begin
            last_addr <= rom_address;
            if (int'(winner) == N_REQ - 1) ptr <= '0;
            else                           ptr <= winner + 1'b1;
         end

         pipe[0] <= '{vld: grant, id: winner};
         for (int k = 1; k < ROM_LAT; k++) pipe[k] <= pipe[k-1];

         // The last stage lines up with the cycle rom_q carries that read's word.
         if (pipe[ROM_LAT-1].vld) begin
            rsp_valid <= onehot_id(pipe[ROM_LAT-1].id);
            rsp_data  <= rom_q;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized scoreboard bench for sprite_rom_arbiter with a behavioural ROM and arbitration model.
module tb_sprite_rom_arbiter;

   localparam int N   = 4;
   localparam int AW  = 10;
   localparam int DW  = 8;
   localparam int LAT = 1;

   logic            vga_clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   rom_address;
   logic [DW-1:0]   rom_q;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            busy;

   logic [DW-1:0]   rom [1 << AW];

   sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .busy        (busy)
   );

   always #5 vga_clk = ~vga_clk;

   // Behavioural ROM: address registered at the edge, word readable for the following cycle.
   always @(posedge vga_clk) rom_q <= rom[rom_address];

   int cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            grant_cyc;
   } exp_t;

   exp_t          sb [$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            mptr  = 0;
   logic [AW-1:0] mlast = '0;
   logic [DW-1:0] mdata = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Grant tracker: reference arbitration, issues expected responses into the scoreboard.
   always @(negedge vga_clk) begin
      int            w;
      int            idx;
      logic [N-1:0]  er;
      logic [AW-1:0] ea;
      logic          eb;
      if (!reset_n) begin
         sb.delete();
         mptr  = 0;
         mlast = '0;
         check("reset_req_ready", 64'(req_ready), 64'(0));
         check("reset_busy", 64'(busy), 64'(0));
      end else begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
         end
         er = '0;
         ea = mlast;
         if (w >= 0) begin
            er[w] = 1'b1;
            ea    = req_addr[w*AW +: AW];
         end
         eb = 1'b0;
         foreach (sb[i])
            if (cyc >= sb[i].grant_cyc + 1 && cyc <= sb[i].grant_cyc + LAT) eb = 1'b1;
         check("req_ready", 64'(req_ready), 64'(er));
         check("rom_address", 64'(rom_address), 64'(ea));
         check("busy", 64'(busy), 64'(eb));
         if (w >= 0) begin
            sb.push_back('{id: w, data: rom[ea], grant_cyc: cyc});
            mptr  = (w + 1) % N;
            mlast = ea;
         end
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT strobes rsp_valid.
   always @(negedge vga_clk) begin
      exp_t         e;
      logic [N-1:0] oh;
      if (!reset_n) begin
         mdata = '0;
         check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
         check("reset_rsp_data", 64'(rsp_data), 64'(0));
      end else if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            e      = sb.pop_front();
            oh     = '0;
            oh[e.id] = 1'b1;
            check("rsp_latency", 64'(cyc), 64'(e.grant_cyc + LAT + 1));
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            mdata = e.data;
         end
      end else begin
         check("rsp_data_hold", 64'(rsp_data), 64'(mdata));
         if (sb.size() > 0 && sb[0].grant_cyc + LAT + 1 <= cyc) begin
            e = sb.pop_front();
            check("rsp_missing", 64'(rsp_valid), 64'(1) << e.id);
         end
      end
   end

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
      req_valid = '0;
      req_addr  = '0;
      reset_n   = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;

      // Idle after reset.
      repeat (10) step();

      // Lone requester 2 at 0x155.
      set_addr(2, 10'h155);
      req_valid = 4'b0100;
      repeat (12) step();

      // All four requesting with distinct addresses.
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) set_addr(i, AW'((c * 37 + i * 211 + 5) % (1 << AW)));
         req_valid = 4'b1111;
         step();
      end

      // Grant to 1 leaves ptr at 2; then 1 and 3 alternate starting with 3.
      req_valid = 4'b0010;
      step();
      req_valid = 4'b1010;
      repeat (5) step();

      // Two back-to-back grants, reset pulsed during the second.
      req_valid = 4'b1111;
      step();
      step();
      @(negedge vga_clk);
      #1 reset_n = 1'b0;
      req_valid = 4'b1100;
      repeat (2) @(posedge vga_clk);
      #1 reset_n = 1'b1;
      repeat (4) step();

      // Single grant at 0x0A3, then idle while addresses keep moving.
      set_addr(0, 10'h0A3);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         req_addr = {N{AW'($urandom)}} ^ (N*AW)'($urandom);
         step();
      end

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
         req_valid = N'($urandom);
         step();
      end

      req_valid = '0;
      repeat (LAT + 4) step();
      check("drain_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
